// File: rtl/bcd_digits_ascii_serializer_if.sv
// Character-stream bundle between the BCD serializer and its source/sink.
// No logic or latency; this is wiring only.
// char_valid_out/char_ready_in form the valid/ready pair; start_in is a strobe.
interface bcd_digits_ascii_serializer_if #(
  parameter int DIGITS_NUM = 6
);
  logic                      start_in;
  logic [4*DIGITS_NUM-1:0]   digits_in;
  logic                      overflow_in;
  logic                      char_ready_in;
  logic                      char_valid_out;
  logic [7:0]                char_out;
  logic                      char_last_out;
  logic                      busy_out;
  logic                      done_out;

  // Serializer side: consumes the snapshot request, produces characters.
  modport master (
    input  start_in,
    input  digits_in,
    input  overflow_in,
    input  char_ready_in,
    output char_valid_out,
    output char_out,
    output char_last_out,
    output busy_out,
    output done_out
  );

  // Source/sink side: issues the request, accepts characters.
  modport slave (
    output start_in,
    output digits_in,
    output overflow_in,
    output char_ready_in,
    input  char_valid_out,
    input  char_out,
    input  char_last_out,
    input  busy_out,
    input  done_out
  );
endinterface

// File: rtl/bcd_digits_ascii_serializer.sv
// Snapshots a packed BCD word on start and streams it as ASCII, MS digit first.
// First character valid 1 cycle after the start edge; then 1 char per accepted handshake.
// char_out/char_last_out hold while char_ready_in=0; leading-zero blanking under BCD_SERIALIZER_LEADING_ZERO_BLANK_EN.
module bcd_digits_ascii_serializer #(
  parameter int DIGITS_NUM = 6
) (
  input  logic clk_in,
  input  logic reset_n_in,
  bcd_digits_ascii_serializer_if.master io
);

  localparam int IDX_W = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS_NUM - 1);

`ifdef BCD_SERIALIZER_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*DIGITS_NUM-1:0] snap_q, snap_d;
  logic                    ovf_q, ovf_d;
  logic                    seen_q, seen_d;
  logic [7:0]              char_q, char_d;
  logic                    last_q, last_d;

  logic [IDX_W-1:0]        next_idx;
  logic [8:0]              mapped;

  // Maps one digit to ASCII; returns {updated seen_nonzero, character}.
  // idx_nz marks a digit that may be blanked (digit 0 never is).
  function automatic logic [8:0] map_digit(
    input logic [3:0] d,
    input logic       seen,
    input logic       idx_nz,
    input logic       ovf
  );
    logic [7:0] c;
    logic       s;
    s = seen;
    c = 8'h30 + {4'h0, d};
    if (ovf) begin
      c = 8'h2D;
    end else if (d > 4'd9) begin
      c = 8'h3F;
      s = 1'b1;
    end else if (BLANK_EN && (d == 4'd0) && !seen && idx_nz) begin
      c = 8'h20;
    end else begin
      s = seen | (d != 4'd0);
    end
    return {s, c};
  endfunction

  // Next-state logic: capture on start, advance one digit per accepted handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    ovf_d    = ovf_q;
    seen_d   = seen_q;
    char_d   = char_q;
    last_d   = last_q;
    next_idx = idx_q - 1'b1;
    mapped   = '0;

    case (state_q)
      ST_IDLE: begin
        if (io.start_in) begin
          snap_d  = io.digits_in;
          ovf_d   = io.overflow_in;
          idx_d   = IDX_TOP;
          mapped  = map_digit(io.digits_in[4*(DIGITS_NUM-1) +: 4], 1'b0,
                              (DIGITS_NUM > 1), io.overflow_in);
          seen_d  = mapped[8];
          char_d  = mapped[7:0];
          last_d  = (DIGITS_NUM == 1);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (io.char_ready_in) begin
          if (idx_q != '0) begin
            mapped = map_digit(snap_q[4*int'(next_idx) +: 4], seen_q,
                               (next_idx != '0), ovf_q);
            idx_d  = next_idx;
            seen_d = mapped[8];
            char_d = mapped[7:0];
            last_d = (next_idx == '0);
          end else begin
            last_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and snapshot registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      seen_q  <= 1'b0;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
      seen_q  <= seen_d;
      char_q  <= char_d;
      last_q  <= last_d;
    end
  end

  assign io.char_valid_out = (state_q == ST_SEND);
  assign io.busy_out       = (state_q == ST_SEND);
  assign io.done_out       = (state_q == ST_DONE);
  assign io.char_out       = char_q;
  assign io.char_last_out  = last_q;

endmodule

// File: tb/tb_bcd_digits_ascii_serializer.sv
// Directed bench for the BCD ASCII serializer with a character scoreboard.
// Expected characters are queued at each start and checked on every handshake.
// Also checks hold-while-stalled, done timing, reset abort and ignored starts.
module tb_bcd_digits_ascii_serializer;
  localparam int N = 6;

  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  bcd_digits_ascii_serializer_if #(.DIGITS_NUM(N)) bus();

  bcd_digits_ascii_serializer #(.DIGITS_NUM(N)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .io         (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc[$];
  logic [8:0] exp_q[$];

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_c = 8'h00;
  logic       prev_l = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      exp_q.push_back({(i == s.len() - 1), c});
    end
  endtask

  // Monitor: sample away from the active edge; scoreboard every handshake.
  always @(negedge clk_in) begin
    cyc++;
    if (!reset_n_in) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (bus.done_out) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (bus.char_valid_out && prev_v && !prev_r) begin
        chk("hold_char", bus.char_out, prev_c);
        chk("hold_last", bus.char_last_out, prev_l);
      end
      if (bus.char_valid_out && bus.char_ready_in) begin
        chk("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("sb_char_last", {bus.char_last_out, bus.char_out}, e);
        end
      end
      prev_v = bus.char_valid_out;
      prev_r = bus.char_ready_in;
      prev_c = bus.char_out;
      prev_l = bus.char_last_out;
    end
  end

  // Called just after a rising edge; start is seen on the next edge.
  task automatic start_xfer(input logic [23:0] d, input logic o, input string s);
    push_str(s);
    bus.digits_in   = d;
    bus.overflow_in = o;
    bus.start_in    = 1'b1;
    @(posedge clk_in);
    #1;
    bus.start_in = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    int n0;
    n0 = done_cnt;
    for (int k = 0; k < 200 && done_cnt == n0; k++) begin
      @(posedge clk_in);
      #1;
      if (toggle) bus.char_ready_in = ~bus.char_ready_in;
    end
    chk("done_seen", (done_cnt > n0), 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    bus.start_in      = 1'b0;
    bus.digits_in     = '0;
    bus.overflow_in   = 1'b0;
    bus.char_ready_in = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", bus.char_valid_out, 0);
    chk("rst_busy",  bus.busy_out, 0);
    chk("rst_done",  bus.done_out, 0);
    chk("rst_char",  bus.char_out, 0);
    chk("rst_last",  bus.char_last_out, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Reset mid-transfer after two characters, then a clean transfer
    bus.char_ready_in = 1'b1;
    start_xfer(24'h123456, 1'b0, "123456");
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    bus.char_ready_in = 1'b0;
    chk("stall_sb_left", exp_q.size(), 4);
    @(posedge clk_in); #2;
    reset_n_in = 1'b0;
    #1;
    chk("abort_valid", bus.char_valid_out, 0);
    chk("abort_busy",  bus.busy_out, 0);
    chk("abort_done",  bus.done_out, 0);
    chk("abort_char",  bus.char_out, 0);
    chk("abort_last",  bus.char_last_out, 0);
    exp_q.delete();
    n0 = done_cnt;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    bus.char_ready_in = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("no_done_after_abort", done_cnt, n0);
    chk("idle_after_abort", bus.char_valid_out, 0);
    @(posedge clk_in); #1;
    start_xfer(24'h123456, 1'b0, "123456");
    wait_done(1'b0);

    // Back-to-back with ready held, exact done timing
`ifdef BCD_SERIALIZER_LEADING_ZERO_BLANK_EN
    start_xfer(24'h012345, 1'b0, " 12345");
`else
    start_xfer(24'h012345, 1'b0, "012345");
`endif
    for (int k = 0; k < N; k++) begin
      @(negedge clk_in);
      chk("b2b_valid", bus.char_valid_out, 1);
      chk("b2b_busy", bus.busy_out, 1);
    end
    @(negedge clk_in);
    chk("done_pulse", bus.done_out, 1);
    chk("done_valid", bus.char_valid_out, 0);
    chk("done_busy", bus.busy_out, 0);
    @(negedge clk_in);
    chk("done_one_cycle", bus.done_out, 0);
    chk("b2b_drained", exp_q.size(), 0);
    @(posedge clk_in); #1;

    // All zeros
`ifdef BCD_SERIALIZER_LEADING_ZERO_BLANK_EN
    start_xfer(24'h000000, 1'b0, "     0");
`else
    start_xfer(24'h000000, 1'b0, "000000");
`endif
    wait_done(1'b0);

    // Ready toggling every cycle
    start_xfer(24'h987654, 1'b0, "987654");
    wait_done(1'b1);
    bus.char_ready_in = 1'b1;

    // Overflow and invalid nibble
    start_xfer(24'h555555, 1'b1, "------");
    wait_done(1'b0);
`ifdef BCD_SERIALIZER_LEADING_ZERO_BLANK_EN
    start_xfer(24'h00A001, 1'b0, "  ?001");
`else
    start_xfer(24'h00A001, 1'b0, "00?001");
`endif
    wait_done(1'b0);

    // Starts during SEND and DONE ignored; digits changed mid-transfer
    n0 = done_cnt;
    start_xfer(24'h135790, 1'b0, "135790");
    bus.digits_in = 24'h999999;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    bus.start_in = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    bus.start_in = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("ignored_start_idle", bus.char_valid_out, 0);
    end
    chk("ignored_done_count", done_cnt, n0 + 1);
    chk("ignored_drained", exp_q.size(), 0);
    @(posedge clk_in); #1;

    // Start held high: one capture every N+2 cycles
`ifdef BCD_SERIALIZER_LEADING_ZERO_BLANK_EN
    push_str("    42");
    push_str("    42");
`else
    push_str("000042");
    push_str("000042");
`endif
    bus.digits_in   = 24'h000042;
    bus.overflow_in = 1'b0;
    bus.start_in    = 1'b1;
    n0 = done_cnt;
    for (int k = 0; k < 50 && done_cnt == n0; k++) begin
      @(posedge clk_in); #1;
    end
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    wait_done(1'b0);
    chk("held_two_dones", done_cnt, n0 + 2);
    if (done_cyc.size() >= 2)
      chk("restart_period", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], N + 2);

    repeat (3) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
